sap1_ram_loader: RTL
====================

SAP1_RAM_LOADER -- requirements
Module: sap1_ram_loader

Interface
REQ-001 SHALL have port clk_i  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ld_req_i  input  1  external loader requests ownership of program RAM (level).
REQ-004 SHALL have port ld_valid_i  input  1  loader byte valid.
REQ-005 SHALL have port ld_data_i  input  8  loader byte.
REQ-006 SHALL have port ld_last_i  input  1  current valid byte is final byte of image.
REQ-007 SHALL have port ld_ready_o  output  1  block accepts loader byte this cycle.
REQ-008 SHALL have port cpu_hltn_i  input  1  CPU halt flag from sequencer, 0 = halted.
REQ-009 SHALL have port cpu_t1_i  input  1  CPU ring counter in address state (T1), i.e. at instruction boundary.
REQ-010 SHALL have port cpu_addr_i  input  4  MAR contents from CPU.
REQ-011 SHALL have port ram_addr_o  output  4  address to 16x8 program RAM.
REQ-012 SHALL have port ram_we_o  output  1  RAM write strobe, active-high, one cycle per byte.
REQ-013 SHALL have port ram_wdata_o  output  8  RAM write data.
REQ-014 SHALL have port cpu_clk_en_o  output  1  CPU clock enable; 0 freezes sequencer and datapath.
REQ-015 SHALL have port cpu_rstn_o  output  1  CPU reset, active-low.
REQ-016 SHALL have port busy_o  output  1  loader owns RAM (any state except RUN).
REQ-017 SHALL have port done_o  output  1  one-cycle pulse when CPU released after load.
REQ-018 SHALL have port count_o  output  5  bytes written in last/current load, 0..16.

Function
REQ-019 SHALL implement FSM states RUN, DRAIN, LOAD, RELEASE.
REQ-020 RUN: ram_addr_o = cpu_addr_i, ram_we_o=0, cpu_clk_en_o=1, cpu_rstn_o=1, ld_ready_o=0.
REQ-021 RUN -> LOAD when ld_req_i=1 and cpu_hltn_i=0; RUN -> DRAIN when ld_req_i=1 and cpu_hltn_i=1.
REQ-022 DRAIN: CPU keeps running; -> LOAD on first cycle with cpu_t1_i=1 or cpu_hltn_i=0; ld_req_i dropping in DRAIN -> RUN, no CPU disturbance.
REQ-023 Entry to LOAD SHALL clear write pointer (4 bit) and count_o to 0 in same edge.
REQ-024 LOAD: cpu_clk_en_o=0, cpu_rstn_o=0, ld_ready_o=1, ram_addr_o = write pointer, ram_wdata_o = ld_data_i.
REQ-025 In LOAD, ram_we_o = ld_valid_i & ld_ready_o (combinational); each accepted byte increments pointer and count_o by 1.
REQ-026 Accepting byte with ld_last_i=1, or accepting 16th byte (pointer 15 -> wraps to 0), SHALL transition to RELEASE; 17th byte never written.
REQ-027 ld_req_i=0 in LOAD without valid byte SHALL abort -> RELEASE; bytes already written kept, count_o holds partial count.
REQ-028 ld_req_i=0 and ld_valid_i=1 same cycle in LOAD: byte written, then RELEASE.
REQ-029 RELEASE: ld_ready_o=0, ram_we_o=0, cpu_rstn_o=0 for exactly 2 cycles (2-bit counter), cpu_clk_en_o=1 during second cycle so sequencer resets to T1.
REQ-030 RELEASE -> RUN after 2nd cycle; done_o=1 for the first RUN cycle only.
REQ-031 ld_req_i still 1 on return to RUN SHALL NOT restart load; new load requires ld_req_i low for at least 1 cycle (rising-edge qualified).
REQ-032 busy_o=1 in DRAIN, LOAD, RELEASE.
REQ-033 count_o SHALL saturate at 16 and hold until next LOAD entry.

Reset
REQ-034 rstn_i=0 SHALL force RUN immediately: cpu_clk_en_o=1, cpu_rstn_o=0 while rstn_i low, ram_we_o=0, ld_ready_o=0, busy_o=0, done_o=0, count_o=0, pointer=0.
REQ-035 Reset during LOAD SHALL abort write with no further ram_we_o; partial RAM contents undefined to CPU.
REQ-036 ld_req_i already high at reset release SHALL NOT start a load (edge qualification armed only after ld_req_i seen low).

Verification
REQ-037 CPU halted (cpu_hltn_i=0), ld_req_i rises, 16 bytes 0x10..0x1F back-to-back -> RAM[0..15]=0x10..0x1F, 16 we pulses, count_o=16, cpu_rstn_o low 2 cycles after last byte, done_o one pulse.
REQ-038 CPU running, ld_req_i rises while cpu_t1_i=0 -> DRAIN, cpu_clk_en_o stays 1 until cpu_t1_i=1, then LOAD next edge.
REQ-039 Load of 3 bytes 0xAA,0xBB,0xCC with ld_last_i on third, ld_valid_i gapped -> RAM[0..2] written, count_o=3, RAM[3..15] untouched.
REQ-040 17 valid bytes without ld_last_i -> only 16 written, ld_ready_o=0 for 17th, state RELEASE.
REQ-041 ld_req_i dropped after 5 bytes -> RELEASE, count_o=5, done_o pulse; ld_req_i held high after done -> no second load.
REQ-042 rstn_i asserted mid-LOAD after 4 bytes -> ram_we_o=0 immediately, busy_o=0, count_o=0, state RUN after reset release.

Source files
------------

// File: rtl/sap1_ram_loader.sv
// Loader that takes over the SAP-1 16x8 program RAM. It drains or halts the CPU,
// writes a byte image from a valid/ready stream, then holds the CPU in reset for two cycles.
module sap1_ram_loader (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       ld_req_i,
    input  logic       ld_valid_i,
    input  logic [7:0] ld_data_i,
    input  logic       ld_last_i,
    output logic       ld_ready_o,
    input  logic       cpu_hltn_i,
    input  logic       cpu_t1_i,
    input  logic [3:0] cpu_addr_i,
    output logic [3:0] ram_addr_o,
    output logic       ram_we_o,
    output logic [7:0] ram_wdata_o,
    output logic       cpu_clk_en_o,
    output logic       cpu_rstn_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [4:0] count_o,
    output logic [1:0] state_o
);

    // Loader stream handshake: a byte moves on every rising edge where
    // ld_valid_i and ld_ready_o are both high. ld_ready_o is high only in LOAD,
    // and the source may change data only after a transfer or while valid is low.

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t     state_q;
    logic [3:0] wptr_q;
    logic [4:0] count_q;
    logic [1:0] rel_cnt_q;
    logic       done_q;
    logic       armed_q;

    logic in_load;
    logic accept;
    logic start_req;
    logic load_end;
    logic load_abort;

    assign in_load    = (state_q == ST_LOAD);
    assign accept     = in_load & ld_valid_i;
    // A new load needs ld_req_i to have been seen low since the previous one.
    assign start_req  = armed_q & ld_req_i;
    assign load_end   = accept & (ld_last_i | (wptr_q == 4'hF) | ~ld_req_i);
    assign load_abort = in_load & ~ld_valid_i & ~ld_req_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_RUN;
            wptr_q    <= 4'd0;
            count_q   <= 5'd0;
            rel_cnt_q <= 2'd0;
            done_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!ld_req_i) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    if (start_req) begin
                        armed_q <= 1'b0;
                        if (!cpu_hltn_i) begin
                            state_q <= ST_LOAD;
                            wptr_q  <= 4'd0;
                            count_q <= 5'd0;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!ld_req_i) begin
                        state_q <= ST_RUN;
                    end else if (cpu_t1_i || !cpu_hltn_i) begin
                        state_q <= ST_LOAD;
                        wptr_q  <= 4'd0;
                        count_q <= 5'd0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wptr_q <= wptr_q + 4'd1;
                        if (count_q != 5'd16) begin
                            count_q <= count_q + 5'd1;
                        end
                    end
                    if (load_end || load_abort) begin
                        state_q   <= ST_RELEASE;
                        rel_cnt_q <= 2'd0;
                    end
                end
                ST_RELEASE: begin
                    if (rel_cnt_q == 2'd1) begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b1;
                    end else begin
                        rel_cnt_q <= rel_cnt_q + 2'd1;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign ld_ready_o  = in_load;
    assign ram_we_o    = ld_valid_i & ld_ready_o;
    assign ram_addr_o  = in_load ? wptr_q : cpu_addr_i;
    assign ram_wdata_o = ld_data_i;
    // Second RELEASE cycle clocks the sequencer while reset is held, parking it at T1.
    assign cpu_clk_en_o = ~(in_load | ((state_q == ST_RELEASE) & (rel_cnt_q == 2'd0)));
    assign cpu_rstn_o   = rstn_i & ~(in_load | (state_q == ST_RELEASE));
    assign busy_o       = (state_q != ST_RUN);
    assign done_o       = done_q;
    assign count_o      = count_q;
    assign state_o      = state_q;

    count_in_range: assert property (@(posedge clk_i) disable iff (!rstn_i) count_q <= 5'd16);
    done_only_in_run: assert property (@(posedge clk_i) disable iff (!rstn_i) done_q |-> (state_q == ST_RUN));

endmodule
